// File: rtl/combat_pkg.sv
// combat_pkg: shared encodings for the two-tank combat sequencer
package combat_pkg;
   localparam logic [2:0] COLL_NONE = 3'b100;
   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_TANK1 = 2'b01;
   localparam logic [1:0] WIN_TANK2 = 2'b10;
   localparam logic [1:0] WIN_DRAW  = 2'b11;
   typedef enum logic [1:0] {B_IDLE, B_FLY, B_COOL} bullet_state_t;
   typedef enum logic [1:0] {S_READY, S_ON, S_RECHARGE} shield_state_t;
   typedef enum logic [1:0] {G_PLAY = 2'b00, G_FREEZE = 2'b01, G_OVER = 2'b10} game_state_t;
   function automatic logic is_hit(input logic [2:0] code);
      return code != COLL_NONE;
   endfunction
endpackage

// File: rtl/combat_controller_if.sv
// combat_controller_if: keys, collision codes and game outputs between datapath and sequencer
interface combat_controller_if #(parameter int HP_W = 2);
   logic            frame_clk, fire1, fire2, shield_req1, shield_req2, start;
   logic [2:0]      disappear, disappear2, tank_bullet, tank_bullet2;
   logic            bullet1_launch, bullet2_launch, bullet1_active, bullet2_active;
   logic            field1On, field2On;
   logic [HP_W-1:0] hp1, hp2;
   logic [1:0]      game_state, winner;
   modport slave (
      input  frame_clk, fire1, fire2, shield_req1, shield_req2, start,
      input  disappear, disappear2, tank_bullet, tank_bullet2,
      output bullet1_launch, bullet2_launch, bullet1_active, bullet2_active,
      output field1On, field2On, hp1, hp2, game_state, winner
   );
   modport master (
      output frame_clk, fire1, fire2, shield_req1, shield_req2, start,
      output disappear, disappear2, tank_bullet, tank_bullet2,
      input  bullet1_launch, bullet2_launch, bullet1_active, bullet2_active,
      input  field1On, field2On, hp1, hp2, game_state, winner
   );
endinterface

// File: rtl/combat_tank_ctrl.sv
// combat_tank_ctrl: one tank's fire capture, bullet lifecycle and shield timing
module combat_tank_ctrl import combat_pkg::*; #(
   parameter int BULLET_LIFE     = 120,
   parameter int COOLDOWN        = 15,
   parameter int SHIELD_FRAMES   = 90,
   parameter int SHIELD_RECHARGE = 240,
   parameter int CNT_W           = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       tick,
   input  logic       play,
   input  logic       over,
   input  logic       force_cool,
   input  logic       restart,
   input  logic       fire,
   input  logic       shield_req,
   input  logic [2:0] tank_code,
   input  logic [2:0] dis_code,
   output logic       launch,
   output logic       active,
   output logic       field_on,
   output logic       hit_opp
);
   bullet_state_t    b_state, b_next;
   shield_state_t    s_state, s_next;
   logic [CNT_W-1:0] b_cnt, b_cnt_nx, s_cnt, s_cnt_nx;
   logic             fire_q, pend, go, kill, cool_end, on_end, rc_end;
   assign go       = tick & play & ~force_cool & pend & (b_state == B_IDLE);
   assign hit_opp  = tick & (b_state == B_FLY) & is_hit(tank_code);
   assign kill     = is_hit(tank_code) | is_hit(dis_code) | (b_cnt == CNT_W'(BULLET_LIFE - 1));
   assign cool_end = b_cnt == CNT_W'(COOLDOWN - 1);
   assign on_end   = s_cnt == CNT_W'(SHIELD_FRAMES - 1);
   assign rc_end   = s_cnt == CNT_W'(SHIELD_RECHARGE - 1);
   assign active   = b_state == B_FLY;
   assign field_on = s_state == S_ON;
   // bullet: a round-ending hit overrides everything, then launch, flight kill, cooldown
   always_comb begin
      b_next   = b_state;
      b_cnt_nx = b_cnt;
      if (force_cool) begin
         b_next   = B_COOL;
         b_cnt_nx = '0;
      end else if (go) begin
         b_next   = B_FLY;
         b_cnt_nx = '0;
      end else if (tick && b_state == B_FLY) begin
         b_next   = kill ? B_COOL : B_FLY;
         b_cnt_nx = kill ? '0 : b_cnt + 1'b1;
      end else if (tick && b_state == B_COOL) begin
         b_next   = cool_end ? B_IDLE : B_COOL;
         b_cnt_nx = cool_end ? '0 : b_cnt + 1'b1;
      end
   end
   // shield: fixed on-time then fixed recharge lockout, key release has no effect
   always_comb begin
      s_next   = s_state;
      s_cnt_nx = s_cnt;
      if (tick && s_state == S_READY && shield_req && !over) begin
         s_next   = S_ON;
         s_cnt_nx = '0;
      end else if (tick && s_state == S_ON) begin
         s_next   = on_end ? S_RECHARGE : S_ON;
         s_cnt_nx = on_end ? '0 : s_cnt + 1'b1;
      end else if (tick && s_state == S_RECHARGE) begin
         s_next   = rc_end ? S_READY : S_RECHARGE;
         s_cnt_nx = rc_end ? '0 : s_cnt + 1'b1;
      end
   end
   // state registers; a pending shot survives only while the bullet idles in play
   always_ff @(posedge Clk) begin
      if (Reset || restart) begin
         b_state <= B_IDLE;
         s_state <= S_READY;
         b_cnt   <= '0;
         s_cnt   <= '0;
         pend    <= 1'b0;
         launch  <= 1'b0;
         fire_q  <= 1'b0;
      end else begin
         b_state <= b_next;
         s_state <= s_next;
         b_cnt   <= b_cnt_nx;
         s_cnt   <= s_cnt_nx;
         pend    <= (fire & ~fire_q) | (pend & ~(tick & (go | (b_state != B_IDLE) | ~play)));
         launch  <= go;
         fire_q  <= fire;
      end
   end
endmodule

// File: rtl/combat_controller.sv
// combat_controller: frame-rate round sequencer owning hp, bullets and shields of both tanks
module combat_controller import combat_pkg::*; #(
   parameter int HP_INIT         = 3,
   parameter int HP_W            = 2,
   parameter int BULLET_LIFE     = 120,
   parameter int COOLDOWN        = 15,
   parameter int SHIELD_FRAMES   = 90,
   parameter int SHIELD_RECHARGE = 240,
   parameter int FREEZE_FRAMES   = 60,
   parameter int CNT_W           = 8
) (
   input logic                Clk,
   input logic                Reset,
   combat_controller_if.slave bus
);
   logic             frame_q, tick, hit1, hit2, force_cool, restart, play, over;
   logic [HP_W-1:0]  hp1, hp2, hp1_nx, hp2_nx;
   logic [CNT_W-1:0] f_cnt, f_cnt_nx;
   logic [1:0]       winner, winner_nx;
   game_state_t      game, game_nx;
   assign play       = game == G_PLAY;
   assign over       = game == G_OVER;
   assign restart    = over & bus.start;
   assign force_cool = tick & play & (hit1 | hit2);
   combat_tank_ctrl #(
      .BULLET_LIFE(BULLET_LIFE), .COOLDOWN(COOLDOWN), .SHIELD_FRAMES(SHIELD_FRAMES),
      .SHIELD_RECHARGE(SHIELD_RECHARGE), .CNT_W(CNT_W)
   ) u_tank1 (
      .Clk(Clk), .Reset(Reset), .tick(tick), .play(play), .over(over),
      .force_cool(force_cool), .restart(restart), .fire(bus.fire1), .shield_req(bus.shield_req1),
      .tank_code(bus.tank_bullet), .dis_code(bus.disappear), .launch(bus.bullet1_launch),
      .active(bus.bullet1_active), .field_on(bus.field1On), .hit_opp(hit1)
   );
   combat_tank_ctrl #(
      .BULLET_LIFE(BULLET_LIFE), .COOLDOWN(COOLDOWN), .SHIELD_FRAMES(SHIELD_FRAMES),
      .SHIELD_RECHARGE(SHIELD_RECHARGE), .CNT_W(CNT_W)
   ) u_tank2 (
      .Clk(Clk), .Reset(Reset), .tick(tick), .play(play), .over(over),
      .force_cool(force_cool), .restart(restart), .fire(bus.fire2), .shield_req(bus.shield_req2),
      .tank_code(bus.tank_bullet2), .dis_code(bus.disappear2), .launch(bus.bullet2_launch),
      .active(bus.bullet2_active), .field_on(bus.field2On), .hit_opp(hit2)
   );
   // hp bookkeeping and round sequencing; a knockout outranks the freeze
   always_comb begin
      hp1_nx    = hp1;
      hp2_nx    = hp2;
      game_nx   = game;
      winner_nx = winner;
      f_cnt_nx  = f_cnt;
      if (restart) begin
         hp1_nx    = HP_W'(HP_INIT);
         hp2_nx    = HP_W'(HP_INIT);
         game_nx   = G_PLAY;
         winner_nx = WIN_NONE;
         f_cnt_nx  = '0;
      end else if (tick && play) begin
         hp1_nx = hp1 - HP_W'(hit2 && hp1 != '0);
         hp2_nx = hp2 - HP_W'(hit1 && hp2 != '0);
         if (hp1_nx == '0 || hp2_nx == '0) begin
            game_nx   = G_OVER;
            winner_nx = {hp1_nx == '0, hp2_nx == '0};
         end else if (hit1 || hit2) begin
            game_nx  = G_FREEZE;
            f_cnt_nx = '0;
         end
      end else if (tick && game == G_FREEZE) begin
         game_nx  = f_cnt == CNT_W'(FREEZE_FRAMES - 1) ? G_PLAY : G_FREEZE;
         f_cnt_nx = f_cnt == CNT_W'(FREEZE_FRAMES - 1) ? '0 : f_cnt + 1'b1;
      end
   end
   // frame tick detection one Clk late, plus game registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_q <= 1'b0;
         tick    <= 1'b0;
         hp1     <= HP_W'(HP_INIT);
         hp2     <= HP_W'(HP_INIT);
         game    <= G_PLAY;
         winner  <= WIN_NONE;
         f_cnt   <= '0;
      end else begin
         frame_q <= bus.frame_clk;
         tick    <= bus.frame_clk & ~frame_q;
         hp1     <= hp1_nx;
         hp2     <= hp2_nx;
         game    <= game_nx;
         winner  <= winner_nx;
         f_cnt   <= f_cnt_nx;
      end
   end
   assign bus.hp1        = hp1;
   assign bus.hp2        = hp2;
   assign bus.game_state = game;
   assign bus.winner     = winner;
endmodule

// File: tb/tb_combat_controller.sv
// tb_combat_controller: directed self-checking bench for the combat sequencer
module tb_combat_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   l1 = 0;
   int   l2 = 0;
   int   base1, base2;
   combat_controller_if #(.HP_W(2)) bus ();
   combat_controller dut (.Clk(clk), .Reset(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.bullet1_launch) l1 <= l1 + 1;
      if (bus.bullet2_launch) l2 <= l2 + 1;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic tick();
      bus.frame_clk = 1'b1;
      repeat (2) @(negedge clk);
      bus.frame_clk = 1'b0;
      repeat (2) @(negedge clk);
   endtask
   task automatic ticks(input int n);
      repeat (n) tick();
   endtask
   task automatic pulse_fire(input bit a, input bit b);
      bus.fire1 = a;
      bus.fire2 = b;
      @(negedge clk);
      bus.fire1 = 1'b0;
      bus.fire2 = 1'b0;
      @(negedge clk);
   endtask
   task automatic hit(input bit a, input bit b);
      bus.tank_bullet  = a ? 3'b000 : 3'b100;
      bus.tank_bullet2 = b ? 3'b000 : 3'b100;
      tick();
      bus.tank_bullet  = 3'b100;
      bus.tank_bullet2 = 3'b100;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      bus.frame_clk = 0; bus.fire1 = 0; bus.fire2 = 0; bus.shield_req1 = 0; bus.shield_req2 = 0;
      bus.start = 0; bus.disappear = 3'b100; bus.disappear2 = 3'b100;
      bus.tank_bullet = 3'b100; bus.tank_bullet2 = 3'b100;
      repeat (2) @(negedge clk);
      do_reset();
      chk("rst_launch1", bus.bullet1_launch, 0);
      chk("rst_active1", bus.bullet1_active, 0);
      chk("rst_field2", bus.field2On, 0);
      chk("rst_hp1", bus.hp1, 3);
      chk("rst_hp2", bus.hp2, 3);
      chk("rst_state", bus.game_state, 0);
      chk("rst_winner", bus.winner, 0);
      base1 = l1;
      bus.fire1 = 1'b1;
      @(negedge clk);
      tick();
      chk("t1_one_launch", l1 - base1, 1);
      chk("t1_active", bus.bullet1_active, 1);
      ticks(5);
      bus.fire1 = 1'b0;
      chk("t1_held_no_refire", l1 - base1, 1);
      do_reset();
      base1 = l1;
      pulse_fire(1, 0);
      tick();
      chk("t2_active", bus.bullet1_active, 1);
      hit(1, 0);
      chk("t2_hp2", bus.hp2, 2);
      chk("t2_hp1", bus.hp1, 3);
      chk("t2_freeze", bus.game_state, 1);
      chk("t2_killed", bus.bullet1_active, 0);
      ticks(30);
      pulse_fire(1, 0);
      ticks(29);
      chk("t2_freeze_59", bus.game_state, 1);
      tick();
      chk("t2_play_60", bus.game_state, 0);
      chk("t2_fire_ignored", l1 - base1, 1);
      pulse_fire(1, 0);
      tick();
      chk("t2_refire", l1 - base1, 2);
      bus.disappear = 3'b010;
      tick();
      bus.disappear = 3'b100;
      chk("t3_obst_kill", bus.bullet1_active, 0);
      chk("t3_hp2_same", bus.hp2, 2);
      chk("t3_state_play", bus.game_state, 0);
      ticks(14);
      pulse_fire(1, 0);
      tick();
      chk("t3_cool_blocks", l1 - base1, 2);
      pulse_fire(1, 0);
      tick();
      chk("t3_cool_done", l1 - base1, 3);
      ticks(119);
      chk("t3_life_119", bus.bullet1_active, 1);
      tick();
      chk("t3_life_120", bus.bullet1_active, 0);
      do_reset();
      bus.shield_req2 = 1'b1;
      tick();
      bus.shield_req2 = 1'b0;
      chk("t4_on", bus.field2On, 1);
      chk("t4_field1_off", bus.field1On, 0);
      ticks(89);
      chk("t4_on_89", bus.field2On, 1);
      tick();
      chk("t4_off_90", bus.field2On, 0);
      ticks(9);
      bus.shield_req2 = 1'b1;
      tick();
      bus.shield_req2 = 1'b0;
      chk("t4_recharge_ignore", bus.field2On, 0);
      ticks(229);
      bus.shield_req2 = 1'b1;
      tick();
      chk("t4_tick330_ignore", bus.field2On, 0);
      tick();
      bus.shield_req2 = 1'b0;
      chk("t4_tick331_accept", bus.field2On, 1);
      do_reset();
      for (int r = 2; r >= 1; r--) begin
         pulse_fire(1, 1);
         tick();
         hit(1, 1);
         chk("t5_hp1", bus.hp1, r);
         chk("t5_hp2", bus.hp2, r);
         chk("t5_freeze", bus.game_state, 1);
         ticks(60);
      end
      pulse_fire(1, 1);
      tick();
      chk("t5_both_fly", {bus.bullet1_active, bus.bullet2_active}, 3);
      hit(1, 1);
      chk("t5_over", bus.game_state, 2);
      chk("t5_draw", bus.winner, 3);
      chk("t5_bullets_off", {bus.bullet1_active, bus.bullet2_active}, 0);
      chk("t5_hp_zero", {bus.hp1, bus.hp2}, 0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("t5_restart_hp", {bus.hp1, bus.hp2}, 4'b1111);
      chk("t5_restart_win", bus.winner, 0);
      chk("t5_restart_state", bus.game_state, 0);
      for (int r = 0; r < 3; r++) begin
         pulse_fire(1, 0);
         tick();
         hit(1, 0);
         if (r < 2) ticks(60);
      end
      chk("t5_win1_state", bus.game_state, 2);
      chk("t5_win1", bus.winner, 1);
      chk("t5_win1_hp1", bus.hp1, 3);
      do_reset();
      base2 = l2;
      pulse_fire(1, 0);
      bus.shield_req1 = 1'b1;
      tick();
      bus.shield_req1 = 1'b0;
      chk("t6_fly", bus.bullet1_active, 1);
      chk("t6_field", bus.field1On, 1);
      pulse_fire(0, 1);
      bus.frame_clk = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.frame_clk = 1'b0;
      chk("t6_no_launch", bus.bullet2_launch, 0);
      chk("t6_active", {bus.bullet1_active, bus.bullet2_active}, 0);
      chk("t6_field_off", bus.field1On, 0);
      chk("t6_hp", {bus.hp1, bus.hp2}, 4'b1111);
      repeat (2) @(negedge clk);
      chk("t6_launch_cnt", l2 - base2, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/combat_controller.md
Name: combat_controller

Overview:
Frame-rate game sequencer for the two-tank arena. It consumes the per-frame collision codes from the obstacle/collision datapath (disappear, disappear2, tank_bullet, tank_bullet2). It owns each tank's bullet lifecycle, force-field (shield) timing, hit points and the round state machine. It drives field1On/field2On back into the collision datapath and bullet launch/kill controls to the bullet movers.

Parameters:
HP_INIT, 3, hit points per tank at round start
HP_W, 2, width of hp outputs; must hold HP_INIT
BULLET_LIFE, 120, max frames a bullet flies before auto-kill
COOLDOWN, 15, frames between bullet kill and next allowed fire
SHIELD_FRAMES, 90, frames a shield stays up
SHIELD_RECHARGE, 240, frames of lockout after shield drops
FREEZE_FRAMES, 60, frames of play freeze after any tank hit
CNT_W, 8, width of all frame counters; must hold the largest frame parameter

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high; all state returns to reset values on the next Clk edge
frame_clk  in  1  vsync-rate level, already synchronous to Clk
fire1, fire2  in  1  fire keys, level
shield_req1, shield_req2  in  1  shield keys, level
start  in  1  restart request, honoured only in G_OVER
disappear, disappear2  in  3  bullet1/bullet2 vs obstacle code; 3'b100 = none, anything else = hit
tank_bullet, tank_bullet2  in  3  bullet1 vs tank2 / bullet2 vs tank1 code; 3'b100 = none
bullet1_launch, bullet2_launch  out  1  one-Clk pulse: bullet mover loads spawn position
bullet1_active, bullet2_active  out  1  bullet is drawn and moving
field1On, field2On  out  1  shield up for tank1/tank2
hp1, hp2  out  HP_W  remaining hit points
game_state  out  2  00 G_PLAY, 01 G_FREEZE, 10 G_OVER
winner  out  2  00 none, 01 tank1, 10 tank2, 11 draw

Behaviour:
- Reset values: all *_launch, *_active and fieldNOn are 0; hp1 = hp2 = HP_INIT; game_state = G_PLAY; winner = 00; all counters 0; pending-fire flags 0.
- tick = frame_clk rising edge, detected with a one-flop delay. tick is a 1-Clk pulse, one Clk after the edge. All game updates below occur only on tick cycles.
- Fire capture: a rising edge on fireN at Clk rate sets pendN. pendN is cleared when consumed or when bullet N is not in B_IDLE at a tick. A held key therefore fires only once.
- Bullet FSM, per tank:
  - B_IDLE to B_FLY on tick when pendN = 1 and game_state = G_PLAY. bulletN_launch pulses on that same Clk; life counter clears.
  - B_FLY on tick, checked in priority order:
    - tank code != 100 goes to B_COOL, and the opponent hp decrements by 1, saturating at 0.
    - else disappear code != 100 goes to B_COOL.
    - else life counter reaching BULLET_LIFE-1 goes to B_COOL.
    - else the life counter increments.
  - B_COOL counts COOLDOWN ticks, then goes to B_IDLE.
  - bulletN_active = 1 only in B_FLY.
  - Entering G_OVER or G_FREEZE forces both bullets to B_COOL.
- Shield FSM, per tank:
  - S_READY to S_ON on tick with shield_reqN = 1 and game_state != G_OVER.
  - S_ON lasts SHIELD_FRAMES ticks, then goes to S_RECHARGE; releasing the key does not end it early.
  - S_RECHARGE lasts SHIELD_RECHARGE ticks, then goes to S_READY.
  - fieldNOn = 1 only in S_ON.
  - Because the datapath masks hits when the field is up, no hp change occurs while shielded.
- Game FSM:
  - G_PLAY: any hp decrement on a tick goes to G_FREEZE, loading FREEZE_FRAMES.
  - G_PLAY: if any hp reaches 0, go to G_OVER instead, taking priority over freeze.
  - G_FREEZE: after FREEZE_FRAMES ticks, return to G_PLAY; fire requests are ignored meanwhile.
  - G_OVER: winner is set on entry. Only hp2 = 0 gives 01; only hp1 = 0 gives 10; both reaching 0 on the same tick gives 11.
  - G_OVER: start = 1 on any Clk reloads hp, clears winner, shields and bullets, and goes to G_PLAY.
- Simultaneous hits on one tick: both decrements apply, and both bullets go to B_COOL.
- Reset mid-flight or mid-shield: immediate return to reset values; no launch pulse is emitted on the reset cycle.

Decomposition:
- Package combat_pkg holds:
  - COLL_NONE = 3'b100.
  - Enums bullet_state_t {B_IDLE, B_FLY, B_COOL}, shield_state_t {S_READY, S_ON, S_RECHARGE} and game_state_t.
  - Winner encodings.
- Sub-module combat_tank_ctrl, instantiated twice, contains one tank's bullet FSM, shield FSM and fire capture. It outputs a hit_opponent pulse.
- The top level keeps tick detection, hp registers and the game FSM.

Test Plan:
1. Reset, pulse fire1, then give 1 tick -> bullet1_launch is high for exactly 1 Clk and bullet1_active = 1; fire1 held for 5 more ticks -> no second launch.
2. Bullet1 flying, tank_bullet = 000 on one tick -> hp2 goes 3→2, game_state = 01 for 60 ticks then 00, bullet1_active = 0, next fire accepted only after 15 further ticks.
3. Bullet1 flying, disappear = 010, no tank code -> bullet killed, hp unchanged, game_state stays 00; with no collisions -> auto-kill after exactly 120 ticks.
4. shield_req2 pulsed 1 tick -> field2On = 1 for exactly 90 ticks; a second request at tick 100 is ignored; a request at tick 331 (after 240 recharge) is accepted.
5. hp1 = hp2 = 1 and both tank codes != 100 on the same tick -> game_state = 10, winner = 11, both bullets inactive; start = 1 -> hp = 3/3, winner = 00, game_state = 00.
6. Reset asserted while bullet1 is in B_FLY and field1On = 1 -> next Clk all outputs are at reset values and bullet1_launch = 0.
